// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared encodings for the single-cycle RV32I-subset control unit: supported
// opcodes, ALU operation codes, writeback-select codes, immediate-format codes
// and the main-decoder-to-ALU-decoder operation class.
// Optional build macro affecting users of this package: CTRL_BNE_EN.
// -----------------------------------------------------------------------------
package ctrl_pkg;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALUcontrol codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Writeback select codes
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Immediate format codes
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Operation class handed from the main decoder to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Purely combinational: maps the main decoder's operation class plus the
// instruction's funct3 / op[5] / funct7[5] fields to the ALU operation code.
// Ports:
//   alu_op_i      operation class from the main decoder
//   funct3_i      instr[14:12]
//   op5_i         instr[5]; distinguishes R-type (1) from I-type ALU (0)
//   funct7_i      instr[30]
//   alu_control_o ALU operation code (ALU_* in ctrl_pkg)
// -----------------------------------------------------------------------------
module alu_decoder
    import ctrl_pkg::*;
(
    input  aluop_e      alu_op_i,
    input  logic [2:0]  funct3_i,
    input  logic        op5_i,
    input  logic        funct7_i,
    output logic [2:0]  alu_control_o
);

    // Select the ALU operation from the operation class and function fields
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000: begin
                        // Only R-type sub sets instr[30]; addi's immediate bit 10 must not select sub
                        if (op5_i && funct7_i) begin
                            alu_control_o = ALU_SUB;
                        end else begin
                            alu_control_o = ALU_ADD;
                        end
                    end
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Main decoder + ALU decoder for the single-cycle RV32I-subset datapath.
// Every control output is combinational from op/funct3/funct7/zero so the
// datapath resolves in the same cycle; only the sticky illegal-opcode debug
// flag is clocked.
// Optional build macro: CTRL_BNE_EN -- when defined, opcode 1100011 with
// funct3 001 decodes as bne (taken when zero is clear) and any branch funct3
// other than 000/001 is illegal. When undefined, every branch funct3 is beq.
// Ports:
//   clk        system clock (status register only)
//   reset      asynchronous active-high reset (status register only)
//   op         instr[6:0]
//   funct3     instr[14:12]
//   funct7     instr[30]
//   zero       ALU result-equals-zero flag
//   branch     conditional branch
//   resSrc     writeback select (RES_* codes)
//   memWrite   data memory write enable
//   aluSrc     ALU B operand: 0 register, 1 immediate
//   inmSrc     immediate format (IMM_* codes)
//   regWrite   register file write enable
//   ALUcontrol ALU operation (ALU_* codes)
//   pcSrc      next PC: 0 PC+4, 1 branch/jump target
//   illegal    sticky: an unsupported opcode has been seen since reset
// -----------------------------------------------------------------------------
module control_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    output logic       branch,
    output logic [1:0] resSrc,
    output logic       memWrite,
    output logic       aluSrc,
    output logic [1:0] inmSrc,
    output logic       regWrite,
    output logic [2:0] ALUcontrol,
    output logic       pcSrc,
    output logic       illegal
);

    logic   jump_s;
    logic   illegal_op_s;
    logic   branch_cond_s;
    aluop_e alu_op_s;
    logic   illegal_q;
    logic   illegal_d;

    // Main decoder: opcode to datapath controls; unsupported opcodes drive all controls low
    always_comb begin
        regWrite     = 1'b0;
        inmSrc       = IMM_I;
        aluSrc       = 1'b0;
        memWrite     = 1'b0;
        resSrc       = RES_ALU;
        branch       = 1'b0;
        jump_s       = 1'b0;
        alu_op_s     = ALUOP_ADD;
        illegal_op_s = 1'b0;
        case (op)
            OP_LOAD: begin
                regWrite = 1'b1;
                inmSrc   = IMM_I;
                aluSrc   = 1'b1;
                resSrc   = RES_MEM;
            end
            OP_STORE: begin
                inmSrc   = IMM_S;
                aluSrc   = 1'b1;
                memWrite = 1'b1;
            end
            OP_RTYPE: begin
                regWrite = 1'b1;
                alu_op_s = ALUOP_FUNCT;
            end
            OP_ITYPE: begin
                regWrite = 1'b1;
                aluSrc   = 1'b1;
                alu_op_s = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
`ifdef CTRL_BNE_EN
                if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
                    inmSrc   = IMM_B;
                    branch   = 1'b1;
                    alu_op_s = ALUOP_SUB;
                end else begin
                    illegal_op_s = 1'b1;
                end
`else
                inmSrc   = IMM_B;
                branch   = 1'b1;
                alu_op_s = ALUOP_SUB;
`endif
            end
            OP_JAL: begin
                regWrite = 1'b1;
                inmSrc   = IMM_J;
                resSrc   = RES_PC4;
                jump_s   = 1'b1;
            end
            default: begin
                illegal_op_s = 1'b1;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op_s),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7_i      (funct7),
        .alu_control_o (ALUcontrol)
    );

    // Branch condition: beq takes on zero; bne (when enabled) takes on not-zero
    always_comb begin
        branch_cond_s = zero;
`ifdef CTRL_BNE_EN
        if (funct3 == 3'b001) begin
            branch_cond_s = ~zero;
        end else begin
            branch_cond_s = zero;
        end
`endif
    end

    assign pcSrc = (branch & branch_cond_s) | jump_s;

    // Sticky illegal-opcode accumulation
    always_comb begin
        illegal_d = illegal_q | illegal_op_s;
    end

    // Illegal-opcode status register; cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed, self-checking bench for control_unit. Control outputs are packed
// as {regWrite, inmSrc, aluSrc, memWrite, resSrc, branch, ALUcontrol, pcSrc}
// and compared against hand-computed vectors; the illegal flag is checked
// around clock edges and an asynchronous reset.
// Honours CTRL_BNE_EN for the bne-specific vectors.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
    logic       branch;
    logic [1:0] resSrc;
    logic       memWrite;
    logic       aluSrc;
    logic [1:0] inmSrc;
    logic       regWrite;
    logic [2:0] ALUcontrol;
    logic       pcSrc;
    logic       illegal;

    int checks;
    int failures;

    logic [11:0] ctl;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .branch     (branch),
        .resSrc     (resSrc),
        .memWrite   (memWrite),
        .aluSrc     (aluSrc),
        .inmSrc     (inmSrc),
        .regWrite   (regWrite),
        .ALUcontrol (ALUcontrol),
        .pcSrc      (pcSrc),
        .illegal    (illegal)
    );

    assign ctl = {regWrite, inmSrc, aluSrc, memWrite, resSrc, branch, ALUcontrol, pcSrc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Apply an instruction on the falling edge and let combinational logic settle
    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        @(negedge clk);
        op     = o;
        funct3 = f3;
        funct7 = f7;
        zero   = z;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        op       = 7'b0000011;
        funct3   = 3'b010;
        funct7   = 1'b0;
        zero     = 1'b0;

        // Reset: flag clear, decode still live while reset is held
        repeat (2) @(posedge clk);
        #1;
        check("reset_illegal", {11'd0, illegal}, 12'd0);
        check("lw_in_reset", ctl, {1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 3'b000, 1'b0});
        @(negedge clk);
        reset = 1'b0;

        drive(7'b0000011, 3'b010, 1'b0, 1'b0);
        check("lw", ctl, {1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 3'b000, 1'b0});
        drive(7'b0100011, 3'b010, 1'b0, 1'b1);
        check("sw", ctl, {1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 1'b0});
        drive(7'b0110011, 3'b000, 1'b0, 1'b0);
        check("r_add", ctl, {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0});
        drive(7'b0110011, 3'b000, 1'b1, 1'b0);
        check("r_sub", ctl, {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'b001, 1'b0});
        drive(7'b0110011, 3'b110, 1'b0, 1'b0);
        check("r_or", ctl, {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'b011, 1'b0});
        drive(7'b0110011, 3'b111, 1'b0, 1'b1);
        check("r_and", ctl, {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010, 1'b0});
        drive(7'b0110011, 3'b010, 1'b0, 1'b0);
        check("r_slt", ctl, {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'b101, 1'b0});
        drive(7'b0110011, 3'b001, 1'b1, 1'b0);
        check("r_other_add", ctl, {1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0});
        drive(7'b0010011, 3'b000, 1'b1, 1'b0);
        check("addi_not_sub", ctl, {1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0});
        drive(7'b0010011, 3'b010, 1'b0, 1'b0);
        check("slti", ctl, {1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 3'b101, 1'b0});
        drive(7'b1100011, 3'b000, 1'b0, 1'b1);
        check("beq_taken", ctl, {1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 3'b001, 1'b1});
        drive(7'b1100011, 3'b000, 1'b0, 1'b0);
        check("beq_not_taken", ctl, {1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 3'b001, 1'b0});
        drive(7'b1101111, 3'b000, 1'b0, 1'b0);
        check("jal_z0", ctl, {1'b1, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 1'b1});
        drive(7'b1101111, 3'b111, 1'b1, 1'b1);
        check("jal_z1", ctl, {1'b1, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000, 1'b1});

`ifdef CTRL_BNE_EN
        drive(7'b1100011, 3'b001, 1'b0, 1'b1);
        check("bne_z1", ctl, {1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 3'b001, 1'b0});
        drive(7'b1100011, 3'b001, 1'b0, 1'b0);
        check("bne_z0", ctl, {1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 3'b001, 1'b1});
        drive(7'b1100011, 3'b100, 1'b0, 1'b1);
        check("branch_f3_100_illegal", ctl, 12'd0);
        @(posedge clk);
        #1;
        check("branch_f3_100_flag", {11'd0, illegal}, 12'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
`else
        drive(7'b1100011, 3'b001, 1'b0, 1'b1);
        check("f3_001_as_beq_z1", ctl, {1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 3'b001, 1'b1});
        drive(7'b1100011, 3'b100, 1'b0, 1'b0);
        check("f3_100_as_beq_z0", ctl, {1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 3'b001, 1'b0});
`endif

        // Only legal opcodes so far (flag cleared above if the bne build set it)
        #1;
        check("illegal_clear_legal", {11'd0, illegal}, 12'd0);

        // Illegal opcode: controls low before the edge, flag set after it
        drive(7'b1111111, 3'b000, 1'b0, 1'b1);
        check("illegal_ctl", ctl, 12'd0);
        check("illegal_pre_edge", {11'd0, illegal}, 12'd0);
        @(posedge clk);
        #1;
        check("illegal_set", {11'd0, illegal}, 12'd1);

        // Sticky across legal instructions
        drive(7'b0000011, 3'b010, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("illegal_sticky", {11'd0, illegal}, 12'd1);

        // Asynchronous reset mid-cycle clears immediately
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("illegal_async_clear", {11'd0, illegal}, 12'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("illegal_stays_clear", {11'd0, illegal}, 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Main decoder plus ALU decoder for the single-cycle RV32I-subset datapath. Decodes opcode, funct3, funct7[5] and the ALU zero flag into datapath controls with zero latency, so the datapath runs in the same cycle. A small clocked status section latches a sticky illegal-opcode flag for debug.

Parameters:
None.

Ports:
clk  input  1  system clock; clocks only the status register
reset  input  1  asynchronous, active-high reset
op  input  7  instruction opcode, instr[6:0]
funct3  input  3  instr[14:12]
funct7  input  1  instr[30], i.e. funct7 bit 5
zero  input  1  ALU result-equals-zero flag
branch  output  1  instruction is a conditional branch
resSrc  output  2  writeback select: 00 ALU, 01 data memory, 10 PC+4
memWrite  output  1  data memory write enable
aluSrc  output  1  ALU B operand: 0 register, 1 immediate
inmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
regWrite  output  1  register file write enable
ALUcontrol  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
pcSrc  output  1  next PC: 0 PC+4, 1 branch/jump target
illegal  output  1  sticky flag: unsupported opcode seen

Behaviour:
- All outputs except illegal are purely combinational from op, funct3, funct7 and zero. There are no registers in that path, and reset does not affect them.
- Main decode, listed as regWrite, inmSrc, aluSrc, memWrite, resSrc, branch, jump, aluOp:
- lw (0000011): 1, 00, 1, 0, 01, 0, 0, 00.
- sw (0100011): 0, 01, 1, 1, 00, 0, 0, 00.
- R-type (0110011): 1, 00, 0, 0, 00, 0, 0, 10.
- beq (1100011): 0, 10, 0, 0, 00, 1, 0, 01.
- I-type ALU (0010011): 1, 00, 1, 0, 00, 0, 0, 10.
- jal (1101111): 1, 11, x, 0, 10, 0, 1, x. Drive aluSrc=0 and aluOp=00.
- Any other opcode: every control output is 0, so no state is written. The combinational internal signal illegal_op is 1.
- Don't-care fields are always driven to 0; no X is ever driven.
- ALU decode:
- aluOp 00 -> add.
- aluOp 01 -> sub.
- aluOp 10, funct3 000 -> sub if op[5] and funct7 are both 1, else add. So addi is never sub.
- aluOp 10, funct3 010 -> slt; 110 -> or; 111 -> and.
- aluOp 10, any other funct3 -> add (000).
- Branch resolution: pcSrc = (branch AND zero) OR jump. This is evaluated in the same cycle as zero.
- illegal register:
- Reset asynchronously to 0.
- On each rising clk edge, illegal <= illegal OR illegal_op.
- Cleared only by reset. A reset asserted mid-operation clears it immediately, regardless of clk.

Optional Feature:
CTRL_BNE_EN:
- Defined: opcode 1100011 with funct3 001 (bne) uses the beq decode row, and pcSrc = (branch AND NOT zero) OR jump. Opcode 1100011 with any funct3 other than 000 or 001 is illegal: all controls 0 and illegal_op 1.
- Undefined: opcode 1100011 is treated as beq for every funct3.

Decomposition:
- Shared package ctrl_pkg holds:
- opcode localparams OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL;
- ALUcontrol codes ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT;
- resSrc codes RES_ALU, RES_MEM, RES_PC4;
- inmSrc codes IMM_I, IMM_S, IMM_B, IMM_J.
- One sub-module, alu_decoder, maps aluOp, funct3, op[5] and funct7 to ALUcontrol. The main decoder, the pcSrc logic and the illegal register stay in control_unit.

Test Plan:
- lw: op=0000011, funct3=010, funct7=0, zero=0 -> regWrite=1, inmSrc=00, aluSrc=1, memWrite=0, resSrc=01, branch=0, ALUcontrol=000, pcSrc=0.
- sw: op=0100011, funct3=010 -> regWrite=0, inmSrc=01, aluSrc=1, memWrite=1, resSrc=00, ALUcontrol=000, pcSrc=0.
- R-type: op=0110011 with funct3=000 -> add (000) when funct7=0, sub (001) when funct7=1. funct3 110 -> 011, 111 -> 010, 010 -> 101. regWrite=1, aluSrc=0 throughout.
- beq: op=1100011, funct3=000 -> with zero=1: branch=1, inmSrc=10, ALUcontrol=001, pcSrc=1; with zero=0: pcSrc=0. With CTRL_BNE_EN and funct3=001, pcSrc is inverted.
- jal and I-type: op=1101111 -> pcSrc=1, resSrc=10, inmSrc=11, regWrite=1. op=0010011 with funct3=000 and funct7=1 -> ALUcontrol=000.
- illegal: op=1111111 for one clk edge -> all controls 0, illegal=1 after the edge and staying 1 with legal ops; assert reset between edges -> illegal=0 immediately.
